// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE layer controller: state encoding, output strobe
// bundle, counter-width helper and the state-to-strobe decode.
package pe_ctrl_pkg;

   localparam int unsigned StateW     = 3;
   localparam int unsigned DefMaxNOps = 16;
   // Run/drain counter must hold n_operations + slack without wrapping.
   localparam int unsigned CntW       = DefMaxNOps + 1;

   typedef enum logic [StateW-1:0] {
      StIdle  = 3'd0,
      StCfg   = 3'd1,
      StBias  = 3'd2,
      StRun   = 3'd3,
      StDrain = 3'd4,
      StDone  = 3'd5
   } state_t;

   typedef struct packed {
      logic cfg_ready;
      logic busy;
      logic load_n_op;
      logic load_base_addr;
      logic load_bias;
      logic read_data;
      logic read_weigth;
      logic acc_addr_en;
      logic acc_op_en;
      logic result_valid;
   } strobe_t;

   function automatic int unsigned cnt_width(input int unsigned n_ops_w);
      return n_ops_w + 1;
   endfunction

   // Strobe pattern that belongs to each state.
   function automatic strobe_t decode_state(input state_t s);
      strobe_t o;
      o = '0;
      o.busy = (s != StIdle);
      case (s)
         StIdle:  o.cfg_ready = 1'b1;
         StCfg: begin
            o.load_n_op      = 1'b1;
            o.load_base_addr = 1'b1;
         end
         StBias:  o.load_bias = 1'b1;
         StRun: begin
            o.read_data   = 1'b1;
            o.read_weigth = 1'b1;
            o.acc_addr_en = 1'b1;
            o.acc_op_en   = 1'b1;
         end
         StDone:  o.result_valid = 1'b1;
         default: o = o;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/pe_controller_if.sv
// Descriptor, PE control and result signals of the layer controller.
interface pe_controller_if #(
   parameter int unsigned max_n_operations = 16,
   parameter int unsigned log_rom_size     = 16,
   parameter int unsigned log_n_mul        = 2,
   parameter int unsigned log_n_add        = 2,
   parameter int unsigned log_bit_width    = 3
) ();

   localparam int unsigned FbW  = 2 ** log_n_mul;
   localparam int unsigned AccW = (2 ** log_n_add) * (2 ** (log_bit_width + 1));

   logic                        cfg_valid;
   logic                        cfg_ready;
   logic [max_n_operations-1:0] cfg_n_operations;
   logic [log_rom_size-1:0]     cfg_base_addr;
   logic [FbW-1:0]              cfg_feedback_sel;
   logic                        pe_read_data;
   logic                        pe_read_weigth;
   logic                        pe_load_n_op;
   logic                        pe_load_base_addr;
   logic                        pe_load_bias;
   logic                        pe_acc_addr_en;
   logic                        pe_acc_op_en;
   logic [max_n_operations-1:0] pe_init_n_operations;
   logic [log_rom_size-1:0]     pe_init_base_addr;
   logic [FbW-1:0]              pe_feedback_sel;
   logic                        pe_end_conv_layer;
   logic [AccW-1:0]             pe_output_reuse;
   logic [AccW-1:0]             result;
   logic                        result_valid;
   logic                        result_ready;
   logic                        busy;
   logic                        err;

   // Controller side.
   modport master (
      input  cfg_valid, cfg_n_operations, cfg_base_addr, cfg_feedback_sel,
      input  pe_end_conv_layer, pe_output_reuse, result_ready,
      output cfg_ready, pe_read_data, pe_read_weigth, pe_load_n_op, pe_load_base_addr,
      output pe_load_bias, pe_acc_addr_en, pe_acc_op_en, pe_init_n_operations,
      output pe_init_base_addr, pe_feedback_sel, result, result_valid, busy, err
   );

   // Host / PE array side.
   modport slave (
      output cfg_valid, cfg_n_operations, cfg_base_addr, cfg_feedback_sel,
      output pe_end_conv_layer, pe_output_reuse, result_ready,
      input  cfg_ready, pe_read_data, pe_read_weigth, pe_load_n_op, pe_load_base_addr,
      input  pe_load_bias, pe_acc_addr_en, pe_acc_op_en, pe_init_n_operations,
      input  pe_init_base_addr, pe_feedback_sel, result, result_valid, busy, err
   );

endinterface

// File: rtl/pe_ctrl_timer.sv
// Loadable down-counter shared by the RUN watchdog and the DRAIN interval.
module pe_ctrl_timer #(
   parameter int unsigned Width = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [Width-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_last
);

   logic [Width-1:0] r_count;

   // Load wins over decrement; saturate at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   // The cycle in which the counter shows 1 is the final cycle of the interval.
   assign o_last = (r_count <= Width'(1));

endmodule

// File: rtl/pe_controller.sv
// Layer controller for the PE array: accepts a descriptor, sequences
// CFG/BIAS/RUN/DRAIN and hands the accumulated result to the consumer.
module pe_controller
   import pe_ctrl_pkg::*;
#(
   parameter int unsigned max_n_operations = 16,
   parameter int unsigned log_rom_size     = 16,
   parameter int unsigned log_n_mul        = 2,
   parameter int unsigned log_n_add        = 2,
   parameter int unsigned log_bit_width    = 3,
   parameter int unsigned drain_cycles     = 4,
   parameter int unsigned slack_cycles     = 8
) (
   input logic             clk,
   input logic             rst,
   pe_controller_if.master bus
);

   localparam int unsigned TimerW = cnt_width(max_n_operations);
   localparam int unsigned FbW    = 2 ** log_n_mul;
   localparam int unsigned AccW   = (2 ** log_n_add) * (2 ** (log_bit_width + 1));

   state_t                      r_state;
   state_t                      w_next_state;
   strobe_t                     r_strb;
   logic [max_n_operations-1:0] r_n_ops;
   logic [log_rom_size-1:0]     r_base;
   logic [FbW-1:0]              r_fb;
   logic [AccW-1:0]             r_result;
   logic                        r_err;

   logic                        w_accept;
   logic                        w_timeout;
   logic                        w_timer_load;
   logic                        w_timer_dec;
   logic                        w_timer_last;
   logic [TimerW-1:0]           w_timer_val;

   // Handshake qualifies on the registered ready so accept and cfg_ready always agree.
   assign w_accept = r_strb.cfg_ready & bus.cfg_valid;

   // Next-state and timer control.
   always_comb begin
      w_next_state = r_state;
      w_timeout    = 1'b0;
      case (r_state)
         StIdle:  if (w_accept) w_next_state = StCfg;
         StCfg:   w_next_state = StBias;
         StBias:  w_next_state = (r_n_ops == '0) ? StDrain : StRun;
         StRun: begin
            if (bus.pe_end_conv_layer) begin
               w_next_state = StDrain;
            end else if (w_timer_last) begin
               w_next_state = StDrain;
               w_timeout    = 1'b1;
            end
         end
         StDrain: if (w_timer_last) w_next_state = StDone;
         StDone:  if (bus.result_ready) w_next_state = StIdle;
         default: w_next_state = StIdle;
      endcase

      w_timer_load = (w_next_state != r_state) &&
                     ((w_next_state == StRun) || (w_next_state == StDrain));
      w_timer_dec  = (r_state == StRun) || (r_state == StDrain);
      w_timer_val  = (w_next_state == StRun) ?
                     (TimerW'(r_n_ops) + TimerW'(slack_cycles)) : TimerW'(drain_cycles);
   end

   pe_ctrl_timer #(
      .Width(TimerW)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_timer_load),
      .i_load_val(w_timer_val),
      .i_dec     (w_timer_dec),
      .o_last    (w_timer_last)
   );

   // State, registered strobes, descriptor, result capture and sticky error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= StIdle;
         r_strb   <= '0;
         r_n_ops  <= '0;
         r_base   <= '0;
         r_fb     <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_strb  <= decode_state(w_next_state);
         if (w_accept) begin
            r_n_ops <= bus.cfg_n_operations;
            r_base  <= bus.cfg_base_addr;
            r_fb    <= bus.cfg_feedback_sel;
         end
         if ((r_state == StDrain) && (w_next_state == StDone)) begin
            r_result <= bus.pe_output_reuse;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.cfg_ready            = r_strb.cfg_ready;
   assign bus.busy                 = r_strb.busy;
   assign bus.pe_load_n_op         = r_strb.load_n_op;
   assign bus.pe_load_base_addr    = r_strb.load_base_addr;
   assign bus.pe_load_bias         = r_strb.load_bias;
   assign bus.pe_read_data         = r_strb.read_data;
   assign bus.pe_read_weigth       = r_strb.read_weigth;
   assign bus.pe_acc_addr_en       = r_strb.acc_addr_en;
   assign bus.pe_acc_op_en         = r_strb.acc_op_en;
   assign bus.result_valid         = r_strb.result_valid;
   assign bus.pe_init_n_operations = r_n_ops;
   assign bus.pe_init_base_addr    = r_base;
   assign bus.pe_feedback_sel      = r_fb;
   assign bus.result               = r_result;
   assign bus.err                  = r_err;

endmodule
